// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the 16-bit CPU core. Holds the word
//                and opcode widths, the opcode values, the sequencer state
//                encoding, the opcode-class record and a helper that extracts
//                the opcode field from an instruction word.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int OP_W   = 7;

    // Opcode values (instr[15:9]). Values not listed here decode as nop.
    localparam logic [OP_W-1:0] OP_NOP = 7'h00;
    localparam logic [OP_W-1:0] OP_MOV = 7'h01;
    localparam logic [OP_W-1:0] OP_LDD = 7'h02;
    localparam logic [OP_W-1:0] OP_LDO = 7'h03;
    localparam logic [OP_W-1:0] OP_LDI = 7'h04;
    localparam logic [OP_W-1:0] OP_STD = 7'h05;
    localparam logic [OP_W-1:0] OP_STO = 7'h06;
    localparam logic [OP_W-1:0] OP_ADD = 7'h07;
    localparam logic [OP_W-1:0] OP_ADI = 7'h08;
    localparam logic [OP_W-1:0] OP_SUB = 7'h09;
    localparam logic [OP_W-1:0] OP_AND = 7'h0A;
    localparam logic [OP_W-1:0] OP_OR  = 7'h0B;
    localparam logic [OP_W-1:0] OP_CMP = 7'h0C;
    localparam logic [OP_W-1:0] OP_CMI = 7'h0D;
    localparam logic [OP_W-1:0] OP_JMP = 7'h0E;

    // Sequencer state encoding, 2 bits wide.
    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_FETCH_IMM = 2'd1,
        ST_MEM       = 2'd2,
        ST_EXEC      = 2'd3
    } state_e;

    // Per-opcode control class.
    typedef struct packed {
        logic two_word;
        logic is_load;
        logic is_store;
    } op_class_t;

    function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: OP_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_op_class.sv
`default_nettype none
// ============================================================================
//  Module      : op_class
//  Description : Purely combinational opcode classifier. Maps a 7-bit opcode
//                to {two_word, is_load, is_store}. Shared by the sequencer,
//                the instruction decoder and any future tracer.
//  Ports       : opcode_i  [6:0]  opcode field of an instruction word
//                class_o          class record (op_class_t)
//  Revision    : 1.0  initial release
// ============================================================================
module op_class
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    output op_class_t       class_o
);

    always_comb begin
        class_o = '0;
        case (opcode_i)
            OP_LDD, OP_LDO: begin
                class_o.two_word = 1'b1;
                class_o.is_load  = 1'b1;
            end
            OP_STD, OP_STO: begin
                class_o.two_word = 1'b1;
                class_o.is_store = 1'b1;
            end
            OP_LDI, OP_ADI, OP_CMI, OP_JMP: begin
                class_o.two_word = 1'b1;
            end
            // Every other opcode, defined or not, is a single-word instruction.
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle control sequencer for the 16-bit CPU core. Owns
//                the single shared memory port and steps every instruction
//                through FETCH, optional FETCH_IMM, optional MEM and EXEC.
//                Holds the IR, the immediate register and the load-data
//                register, and emits the one-cycle commit strobe that
//                qualifies all architectural writes in the datapath.
//  Ports       : clk            core clock, rising edge
//                rst_n          synchronous reset, active low
//                run_i          allows the start of a new instruction fetch
//                pc_i           current PC value
//                alu_out_i      ALU result, data address for loads/stores
//                reg_r_data_i   register-file right port, store data
//                mem_rdata_i    memory read data (valid with mem_ack_i)
//                mem_ack_i      memory completes the current request
//                mem_req_o      memory request
//                mem_we_o       1 = write, 0 = read
//                mem_addr_o     memory address
//                mem_wdata_o    memory write data (0 outside MEM)
//                instr_o        instruction register
//                imm_o          immediate register
//                ld_data_o      registered load data
//                pc_adv_o       PC += 1 after word 0 of a two-word instr
//                commit_o       one-cycle execute strobe
//                busy_o         state != FETCH or a request is pending
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] alu_out_i,
    input  logic [WORD_W-1:0] reg_r_data_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] imm_o,
    output logic [WORD_W-1:0] ld_data_o,
    output logic              pc_adv_o,
    output logic              commit_o,
    output logic              busy_o
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] imm_q,   imm_d;
    logic [WORD_W-1:0] ld_data_q, ld_data_d;

    op_class_t fetch_cls;   // class of the word on the read bus (FETCH only)
    op_class_t ir_cls;      // class of the instruction held in IR
    logic      xfer;        // request accepted by memory this cycle

    // ------------------------------------------------------------------------
    // Classification. During FETCH the branch decision must be made from the
    // word arriving on the bus since IR is only loaded at the end of the cycle;
    // in all later states IR is the source. Two instances keep the bus-control
    // path (IR-based) free of any dependency on mem_rdata.
    // ------------------------------------------------------------------------
    op_class u_cls_fetch (
        .opcode_i (opcode_of(mem_rdata_i)),
        .class_o  (fetch_cls)
    );

    op_class u_cls_ir (
        .opcode_i (opcode_of(instr_q)),
        .class_o  (ir_cls)
    );

    // ------------------------------------------------------------------------
    // Memory port. Everything here comes from state, IR and registered
    // datapath inputs, so the request stays stable through wait states.
    // mem_req is gated by rst_n so an outstanding request is dropped in the
    // very cycle reset is applied.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = pc_i;
        mem_wdata_o = '0;
        case (state_q)
            ST_FETCH: begin
                mem_req_o = run_i;
            end
            ST_FETCH_IMM: begin
                // PC has already been advanced by pc_adv in FETCH.
                mem_req_o = 1'b1;
            end
            ST_MEM: begin
                mem_req_o   = 1'b1;
                mem_we_o    = ir_cls.is_store;
                mem_addr_o  = alu_out_i;
                mem_wdata_o = reg_r_data_i;
            end
            default: ;
        endcase
        if (!rst_n) begin
            mem_req_o = 1'b0;
            mem_we_o  = 1'b0;
        end
    end

    // An ack with no request is meaningless and is ignored here.
    assign xfer = mem_req_o & mem_ack_i;

    // ------------------------------------------------------------------------
    // Next-state and strobe logic.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        ld_data_d = ld_data_q;
        pc_adv_o  = 1'b0;
        commit_o  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (xfer) begin
                    instr_d = mem_rdata_i;
                    if (fetch_cls.two_word) begin
                        pc_adv_o = 1'b1;
                        state_d  = ST_FETCH_IMM;
                    end else begin
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_FETCH_IMM: begin
                if (xfer) begin
                    imm_d = mem_rdata_i;
                    if (ir_cls.is_load || ir_cls.is_store) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_MEM: begin
                if (xfer) begin
                    if (ir_cls.is_load) begin
                        ld_data_d = mem_rdata_i;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                commit_o = 1'b1;
                state_d  = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        // No strobe may escape while reset is being applied.
        if (!rst_n) begin
            pc_adv_o = 1'b0;
            commit_o = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            instr_q   <= '0;
            imm_q     <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign instr_o   = instr_q;
    assign imm_o     = imm_q;
    assign ld_data_o = ld_data_q;
    assign busy_o    = (state_q != ST_FETCH) || mem_req_o;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench for cpu_sequencer. A behavioural model
//                expands each instruction into the list of bus transfers,
//                pc_adv and commit it must produce; a compare process checks
//                the DUT against that list every cycle. Directed scenarios
//                add literal expectations on cycle counts and register values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam int K_NONE   = -1;
    localparam int K_FETCH  = 0;
    localparam int K_PCADV  = 1;
    localparam int K_IMM    = 2;
    localparam int K_DATA   = 3;
    localparam int K_COMMIT = 4;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] ld;
        int          len;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic [15:0] pc, alu_out, reg_r_data;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we, pc_adv, commit, busy;
    logic [15:0] mem_addr, mem_wdata, instr, imm, ld_data;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run),
        .pc_i         (pc),
        .alu_out_i    (alu_out),
        .reg_r_data_i (reg_r_data),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .instr_o      (instr),
        .imm_o        (imm),
        .ld_data_o    (ld_data),
        .pc_adv_o     (pc_adv),
        .commit_o     (commit),
        .busy_o       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Memory: addresses below 0x100 are program, at/above are data. Each
    // region has its own wait-state count.
    // ------------------------------------------------------------------------
    logic [15:0] mem [0:1023];
    int fw, dw, wcnt, needed;

    always_comb needed = (mem_addr >= 16'h0100) ? dw : fw;
    assign mem_ack   = mem_req && (wcnt >= needed);
    assign mem_rdata = mem[mem_addr[9:0]];

    initial wcnt = 0;
    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    // Datapath stand-in for the PC register.
    logic        pc_load;
    logic [15:0] pc_new;
    initial pc = 16'h0000;
    always @(posedge clk) begin
        if (pc_load)     pc <= pc_new;
        else if (pc_adv) pc <= pc + 16'd1;
        else if (commit) pc <= (instr[15:9] == 7'h0E) ? imm : pc + 16'd1;
    end

    // ------------------------------------------------------------------------
    // Behavioural model: expected event list for the instruction at pc.
    // ------------------------------------------------------------------------
    ev_t         q[$];
    bit          inflight = 0;
    bit          started  = 0;
    int          cyc = 0, start_cyc = 0;
    logic [15:0] m_imm = 16'h0, m_ld = 16'h0;
    int          n_pcadv = 0, n_commit = 0, n_writes = 0, n_d100 = 0;
    logic [15:0] last_waddr = 16'h0, last_wdata = 16'h0;

    function automatic ev_t mk(input int kind, input logic [15:0] addr,
                               input logic we, input logic [15:0] wdata);
        ev_t e;
        e.kind = kind; e.addr = addr; e.we = we; e.wdata = wdata;
        e.instr = 16'h0; e.imm = 16'h0; e.ld = 16'h0; e.len = 0;
        return e;
    endfunction

    function void build();
        logic [15:0] w, a1;
        logic [6:0]  op;
        bit          tw, ld, st;
        ev_t         c;
        int          len;
        w  = mem[pc[9:0]];
        a1 = pc + 16'd1;
        op = w[15:9];
        ld = (op == 7'h02) || (op == 7'h03);
        st = (op == 7'h05) || (op == 7'h06);
        tw = ld || st || (op == 7'h04) || (op == 7'h08) || (op == 7'h0D) || (op == 7'h0E);
        c  = mk(K_COMMIT, 16'h0, 1'b0, 16'h0);
        c.instr = w;
        c.imm   = tw ? mem[a1[9:0]] : m_imm;
        c.ld    = ld ? mem[alu_out[9:0]] : m_ld;
        len = 2 + fw;
        q.push_back(mk(K_FETCH, pc, 1'b0, 16'h0));
        if (tw) begin
            q.push_back(mk(K_PCADV, 16'h0, 1'b0, 16'h0));
            q.push_back(mk(K_IMM, a1, 1'b0, 16'h0));
            len += 1 + fw;
        end
        if (ld || st) begin
            q.push_back(mk(K_DATA, alu_out, st, reg_r_data));
            len += 1 + dw;
        end
        c.len = len;
        q.push_back(c);
    endfunction

    always @(negedge clk) begin : p_compare
        ev_t h;
        bit  fa;
        cyc++;
        if (!rst_n) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_commit", commit, 0);
            chk("rst_pc_adv", pc_adv, 0);
            q.delete();
            inflight = 0; started = 0; m_imm = 16'h0; m_ld = 16'h0;
        end else begin
            if (!inflight && !run) begin q.delete(); started = 0; end
            if (!inflight && run && q.size() == 0) build();
            if (!inflight && mem_req && !started) begin started = 1; start_cyc = cyc; end
            h.kind = K_NONE;
            if (q.size() > 0) h = q[0];

            if (!inflight) chk("mem_req_idle", mem_req, run);
            else           chk("mem_req_busy", mem_req, (h.kind == K_IMM) || (h.kind == K_DATA));
            chk("busy", busy, mem_req || inflight);
            chk("commit", commit, inflight && (h.kind == K_COMMIT));
            chk("adv_commit_excl", pc_adv && commit, 0);
            if (mem_req && h.kind != K_NONE) begin
                chk("mem_addr", mem_addr, h.addr);
                chk("mem_we", mem_we, h.we);
                chk("mem_wdata", mem_wdata, h.wdata);
            end else if (!mem_req) begin
                chk("bus_idle", {mem_we, mem_wdata}, 0);
            end
            if (mem_req && mem_addr == 16'h0100 && !mem_we) n_d100++;

            fa = 0;
            if (mem_req && mem_ack && q.size() > 0) begin
                if (h.kind == K_FETCH) begin fa = 1; inflight = 1; end
                if (h.kind == K_DATA && mem_we) begin
                    n_writes++; last_waddr = mem_addr; last_wdata = mem_wdata;
                end
                void'(q.pop_front());
                h.kind = K_NONE;
                if (q.size() > 0) h = q[0];
            end
            if (fa && h.kind == K_PCADV) begin
                chk("pc_adv", pc_adv, 1);
                n_pcadv++;
                void'(q.pop_front());
            end else begin
                chk("pc_adv", pc_adv, 0);
            end
            if (commit && inflight && h.kind == K_COMMIT) begin
                chk("commit_instr", instr, h.instr);
                chk("commit_imm", imm, h.imm);
                chk("commit_ld_data", ld_data, h.ld);
                chk("commit_cycles", cyc - start_cyc + 1, h.len);
                m_imm = h.imm; m_ld = h.ld;
                n_commit++;
                void'(q.pop_front());
                inflight = 0; started = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers. All tasks start and end 2 time units after a posedge.
    // ------------------------------------------------------------------------
    task automatic set_pc(input logic [15:0] v);
        pc_new  = v;
        pc_load = 1'b1;
        @(posedge clk); #2;
        pc_load = 1'b0;
    endtask

    // Runs exactly one instruction: run is held until the fetch is accepted.
    task automatic run_one(output int cycles, output logic [15:0] faddr);
        int n;
        bit acked;
        n = 0; acked = 0; cycles = -1; faddr = 16'hFFFF;
        run = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (!acked && mem_req && mem_ack) begin acked = 1; faddr = mem_addr; end
            if (commit) begin cycles = n; break; end
            if (acked) begin @(posedge clk); #2; run = 1'b0; end
        end
        run = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            chk("idle_mem_req", mem_req, 0);
            chk("idle_busy", busy, 0);
            @(posedge clk); #2;
        end
    endtask

    initial begin : p_stim
        int          cyc_n;
        logic [15:0] fa;
        int          base;
        bit          found;

        rst_n = 1'b0; run = 1'b0; pc_load = 1'b0; pc_new = 16'h0;
        alu_out = 16'h0; reg_r_data = 16'h0; fw = 0; dw = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0]      = 16'h0E00;                      // add
        mem[4]      = 16'h0840; mem[5]  = 16'h1234;  // ldi
        mem[8]      = 16'h0440; mem[9]  = 16'h0100;  // ldd
        mem[12]     = 16'h0A00; mem[13] = 16'h0200;  // std
        mem[16]     = 16'h0600; mem[17] = 16'h0300;  // ldo (word 1 doubles as mov)
        mem[20]     = 16'h1C00; mem[21] = 16'h0040;  // jmp 0x40
        mem[16'h40] = 16'h0E00;                      // add
        mem[16'h41] = 16'h1A00; mem[16'h42] = 16'h0007; // cmi
        mem[16'h43] = 16'hFE00;                      // undefined opcode
        mem[16'h100] = 16'hBEEF;

        // Reset state
        @(posedge clk); #2;
        @(negedge clk); #1;
        chk("reset_instr", instr, 16'h0000);
        chk("reset_imm", imm, 16'h0000);
        chk("reset_ld_data", ld_data, 16'h0000);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle_check(2);

        // One-word add at pc=0
        set_pc(16'h0000);
        base = n_pcadv;
        run_one(cyc_n, fa);
        chk("add_cycles", cyc_n, 2);
        chk("add_fetch_addr", fa, 16'h0000);
        chk("add_ir", instr, 16'h0E00);
        chk("add_no_pc_adv", n_pcadv - base, 0);

        // ldi at pc=4
        set_pc(16'h0004);
        base = n_pcadv;
        run_one(cyc_n, fa);
        chk("ldi_cycles", cyc_n, 3);
        chk("ldi_fetch_addr", fa, 16'h0004);
        chk("ldi_pc_adv_count", n_pcadv - base, 1);
        chk("ldi_imm", imm, 16'h1234);

        // ldd with two data wait states
        set_pc(16'h0008);
        alu_out = 16'h0100; dw = 2;
        base = n_d100;
        run_one(cyc_n, fa);
        chk("ldd_cycles", cyc_n, 6);
        chk("ldd_mem_hold", n_d100 - base, 3);
        chk("ldd_ld_data", ld_data, 16'hBEEF);
        dw = 0;

        // std
        set_pc(16'h000C);
        alu_out = 16'h0200; reg_r_data = 16'h5A5A;
        base = n_writes;
        run_one(cyc_n, fa);
        chk("std_cycles", cyc_n, 4);
        chk("std_write_count", n_writes - base, 1);
        chk("std_waddr", last_waddr, 16'h0200);
        chk("std_wdata", last_wdata, 16'h5A5A);
        chk("std_ld_data_kept", ld_data, 16'hBEEF);

        // Reset during a MEM wait of ldo
        set_pc(16'h0010);
        alu_out = 16'h0300; dw = 5;
        base = n_commit;
        run = 1'b1;
        @(posedge clk); #2;
        run = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'h0300) begin found = 1; break; end
        end
        chk("rstmid_reached_mem", found, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_req_dropped", mem_req, 0);
        chk("rstmid_no_commit", commit, 0);
        @(posedge clk); #2;
        @(negedge clk); #1;
        chk("rstmid_instr", instr, 16'h0000);
        chk("rstmid_imm", imm, 16'h0000);
        chk("rstmid_ld_data", ld_data, 16'h0000);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_commits", n_commit - base, 0);
        @(posedge clk); #2;
        rst_n = 1'b1; dw = 0;
        run_one(cyc_n, fa);
        chk("rstmid_refetch_addr", fa, 16'h0011);
        chk("rstmid_refetch_cycles", cyc_n, 2);
        chk("rstmid_refetch_ir", instr, 16'h0300);

        // Idle, then jmp with run dropped during FETCH_IMM
        idle_check(3);
        set_pc(16'h0014);
        run_one(cyc_n, fa);
        chk("jmp_cycles", cyc_n, 3);
        chk("jmp_imm", imm, 16'h0040);
        idle_check(3);

        // Fetch wait states: add, cmi; then an undefined opcode
        fw = 1;
        run_one(cyc_n, fa);
        chk("add_wait_fetch_addr", fa, 16'h0040);
        chk("add_wait_cycles", cyc_n, 3);
        run_one(cyc_n, fa);
        chk("cmi_wait_cycles", cyc_n, 5);
        chk("cmi_imm", imm, 16'h0007);
        fw = 0;
        run_one(cyc_n, fa);
        chk("undef_fetch_addr", fa, 16'h0043);
        chk("undef_cycles", cyc_n, 2);
        idle_check(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
